// File: rtl/atp_cash_collector_if.sv
// Cash collector bus: bill/start/cancel and validator note handshake in, status and totals out.
interface atp_cash_collector_if #(
    parameter int AMT_W = 11,
    parameter int TOT_W = 12
);
    logic             start;
    logic [AMT_W-1:0] bill_amount;
    logic             cancel;
    logic             note_valid;
    logic [2:0]       note_code;
    logic             note_ack;
    logic             note_reject;
    logic             busy;
    logic             done;
    logic             paid_ok;
    logic [TOT_W-1:0] tendered;
    logic [TOT_W-1:0] change;
    logic             refund;
    logic             error;

    modport master (
        output start, bill_amount, cancel, note_valid, note_code,
        input  note_ack, note_reject, busy, done, paid_ok, tendered, change, refund, error
    );

    modport slave (
        input  start, bill_amount, cancel, note_valid, note_code,
        output note_ack, note_reject, busy, done, paid_ok, tendered, change, refund, error
    );
endinterface

// File: rtl/atp_cash_collector.sv
// Counts cash notes against a bill; reports tendered, change and paid/refund outcome. Optional idle abort: ATP_COLLECT_TIMEOUT_EN.
// Latency: note_ack/note_reject 1 cycle after sampling; done 2 cycles after the final note, 1 cycle after cancel.
// Backpressure: a held note_valid is sampled only while no response pulse is out, so each note is counted once.
module atp_cash_collector #(
    parameter int AMT_W       = 11,
    parameter int TOT_W       = 12,
    parameter int MAX_NOTES   = 15,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    atp_cash_collector_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_NOTES + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, SETTLE, REFUND} state_t;

    state_t           state;
    logic [AMT_W-1:0] bill;
    logic [CNT_W-1:0] note_cnt;
    logic [TOT_W-1:0] tendered;
    logic [TOT_W-1:0] change;
    logic             note_ack;
    logic             note_reject;
    logic             busy;
    logic             done;
    logic             paid_ok;
    logic             refund;
    logic             error;

    function automatic logic [9:0] denom(input logic [2:0] code);
        case (code)
            3'd0:    denom = 10'd10;
            3'd1:    denom = 10'd20;
            3'd2:    denom = 10'd50;
            3'd3:    denom = 10'd100;
            3'd4:    denom = 10'd200;
            3'd5:    denom = 10'd500;
            default: denom = 10'd0;
        endcase
    endfunction

    logic           note_smp;
    logic [TOT_W:0] sum;
    logic           code_bad;
    logic           full;
    logic           take;
    logic           paid_now;
    logic           tmo_hit;

    assign note_smp = bus.note_valid && !note_ack && !note_reject;
    assign sum      = {1'b0, tendered} + (TOT_W+1)'(denom(bus.note_code));
    assign code_bad = bus.note_code[2] & bus.note_code[1];
    assign full     = (note_cnt == CNT_W'(MAX_NOTES));
    // Carry out of the accumulator means the note would overflow tendered.
    assign take     = note_smp && !code_bad && !full && !sum[TOT_W];
    assign paid_now = (sum >= (TOT_W+1)'(bill));

`ifdef ATP_COLLECT_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || state != COLLECT || take) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = (state == COLLECT) && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYC == 0);
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            bill        <= '0;
            note_cnt    <= '0;
            tendered    <= '0;
            change      <= '0;
            note_ack    <= 1'b0;
            note_reject <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            paid_ok     <= 1'b0;
            refund      <= 1'b0;
            error       <= 1'b0;
        end else begin
            note_ack    <= 1'b0;
            note_reject <= 1'b0;
            done        <= 1'b0;
            refund      <= 1'b0;
            error       <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.bill_amount != '0) begin
                            bill     <= bus.bill_amount;
                            tendered <= '0;
                            change   <= '0;
                            paid_ok  <= 1'b0;
                            note_cnt <= '0;
                            busy     <= 1'b1;
                            state    <= COLLECT;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    // Abort outcome is published on entry so done trails cancel by one cycle.
                    if (bus.cancel || tmo_hit) begin
                        note_reject <= note_smp;
                        change      <= tendered;
                        paid_ok     <= 1'b0;
                        refund      <= 1'b1;
                        done        <= 1'b1;
                        error       <= tmo_hit;
                        state       <= REFUND;
                    end else if (take) begin
                        tendered <= sum[TOT_W-1:0];
                        note_cnt <= note_cnt + 1'b1;
                        note_ack <= 1'b1;
                        if (paid_now) begin
                            state <= SETTLE;
                        end
                    end else if (note_smp) begin
                        note_reject <= 1'b1;
                    end
                end
                SETTLE: begin
                    change  <= tendered - TOT_W'(bill);
                    paid_ok <= 1'b1;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                REFUND: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.note_ack    = note_ack;
    assign bus.note_reject = note_reject;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.paid_ok     = paid_ok;
    assign bus.tendered    = tendered;
    assign bus.change      = change;
    assign bus.refund      = refund;
    assign bus.error       = error;
endmodule

// File: tb/tb_atp_cash_collector.sv
// Self-checking bench for atp_cash_collector: directed scenarios plus randomized transactions against a note-level model.
module tb_atp_cash_collector;
    localparam int AMT_W       = 11;
    localparam int TOT_W       = 12;
    localparam int MAX_NOTES   = 15;
    localparam int TIMEOUT_CYC = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    atp_cash_collector_if #(.AMT_W(AMT_W), .TOT_W(TOT_W)) bus ();

    atp_cash_collector #(
        .AMT_W(AMT_W), .TOT_W(TOT_W), .MAX_NOTES(MAX_NOTES), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int ack_cnt = 0;
    int done_cnt = 0;

    always @(posedge clk) begin
        cyc++;
        if (bus.note_ack) ack_cnt++;
        if (bus.done) done_cnt++;
    end

    int den_tab[8] = '{10, 20, 50, 100, 200, 500, 0, 0};
    int m_tend;
    int m_notes;

    function automatic bit model_accepts(input int code);
        return (code < 6) && (m_notes < MAX_NOTES) && (m_tend + den_tab[code] <= (1 << TOT_W) - 1);
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int bill);
        bus.start = 1'b1;
        bus.bill_amount = AMT_W'(bill);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_note(input logic [2:0] code, output logic got_ack, output logic got_rej);
        got_ack = 1'b0;
        got_rej = 1'b0;
        bus.note_valid = 1'b1;
        bus.note_code = code;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.note_ack || bus.note_reject) begin
                got_ack = bus.note_ack;
                got_rej = bus.note_reject;
                break;
            end
        end
        bus.note_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        n_vec++;
        if ({bus.note_ack, bus.note_reject, bus.busy, bus.done, bus.paid_ok, bus.refund, bus.error} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_flags got %b want 0000000",
                     {bus.note_ack, bus.note_reject, bus.busy, bus.done, bus.paid_ok, bus.refund, bus.error});
        end
        n_vec++;
        if (bus.tendered !== '0 || bus.change !== '0) begin
            n_err++;
            $display("FAIL reset_totals got %0d/%0d want 0/0", bus.tendered, bus.change);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_paid_two_notes();
        logic a1, r1, a2, r2;
        int a0;
        a0 = ack_cnt;
        do_start(130);
        send_note(3'd3, a1, r1);
        send_note(3'd2, a2, r2);
        n_vec++;
        if ({a1, r1, a2, r2} !== 4'b1010) begin
            n_err++;
            $display("FAIL two_notes_resp got %b want 1010", {a1, r1, a2, r2});
        end
        n_vec++;
        if (bus.tendered !== 12'd150) begin
            n_err++;
            $display("FAIL two_notes_tendered got %0d want 150", bus.tendered);
        end
        tick();
        n_vec++;
        if ({bus.done, bus.paid_ok, bus.refund} !== 3'b110 || bus.change !== 12'd20) begin
            n_err++;
            $display("FAIL two_notes_done got d/p/r=%b change=%0d want 110 change=20",
                     {bus.done, bus.paid_ok, bus.refund}, bus.change);
        end
        n_vec++;
        if (ack_cnt - a0 !== 2) begin
            n_err++;
            $display("FAIL two_notes_ackcount got %0d want 2", ack_cnt - a0);
        end
        tick();
    endtask

    task automatic test_held_note();
        int a0, t_ack, t_done;
        a0 = ack_cnt;
        t_ack = -1;
        t_done = -1;
        do_start(100);
        bus.note_valid = 1'b1;
        bus.note_code = 3'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.note_ack && t_ack < 0) t_ack = i;
            if (bus.done && t_done < 0) t_done = i;
        end
        bus.note_valid = 1'b0;
        n_vec++;
        if (ack_cnt - a0 !== 1) begin
            n_err++;
            $display("FAIL held_ackcount got %0d want 1", ack_cnt - a0);
        end
        n_vec++;
        if (t_ack !== 0 || t_done !== 1) begin
            n_err++;
            $display("FAIL held_latency got ack@%0d done@%0d want ack@0 done@1", t_ack, t_done);
        end
        n_vec++;
        if (bus.tendered !== 12'd100 || bus.change !== 12'd0 || bus.paid_ok !== 1'b1) begin
            n_err++;
            $display("FAIL held_totals got t=%0d c=%0d p=%b want t=100 c=0 p=1",
                     bus.tendered, bus.change, bus.paid_ok);
        end
        tick();
    endtask

    task automatic test_reject_then_ack();
        logic a1, r1, a2, r2;
        do_start(500);
        send_note(3'd7, a1, r1);
        send_note(3'd4, a2, r2);
        n_vec++;
        if ({a1, r1, a2, r2} !== 4'b0110) begin
            n_err++;
            $display("FAIL rej_ack_resp got %b want 0110", {a1, r1, a2, r2});
        end
        n_vec++;
        if (bus.tendered !== 12'd200 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL rej_ack_state got t=%0d busy=%b want t=200 busy=1", bus.tendered, bus.busy);
        end
        tick();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        n_vec++;
        if ({bus.done, bus.refund, bus.paid_ok} !== 3'b110 || bus.change !== 12'd200) begin
            n_err++;
            $display("FAIL rej_ack_cancel got d/r/p=%b change=%0d want 110 change=200",
                     {bus.done, bus.refund, bus.paid_ok}, bus.change);
        end
        tick();
    endtask

    task automatic test_cancel_with_note();
        logic a1, r1, a2, r2;
        do_start(1000);
        send_note(3'd4, a1, r1);
        send_note(3'd4, a2, r2);
        tick();
        bus.cancel = 1'b1;
        bus.note_valid = 1'b1;
        bus.note_code = 3'd2;
        tick();
        bus.cancel = 1'b0;
        bus.note_valid = 1'b0;
        n_vec++;
        if ({bus.note_reject, bus.note_ack, bus.done, bus.refund, bus.paid_ok} !== 5'b10110) begin
            n_err++;
            $display("FAIL cancel_note_flags got %b want 10110",
                     {bus.note_reject, bus.note_ack, bus.done, bus.refund, bus.paid_ok});
        end
        n_vec++;
        if (bus.change !== 12'd400 || bus.tendered !== 12'd400) begin
            n_err++;
            $display("FAIL cancel_note_totals got c=%0d t=%0d want 400/400", bus.change, bus.tendered);
        end
        tick();
        n_vec++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL cancel_note_idle got busy=%b done=%b want 0/0", bus.busy, bus.done);
        end
    endtask

    task automatic test_zero_bill();
        do_start(0);
        n_vec++;
        if (bus.error !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL zero_bill got err=%b busy=%b want 1/0", bus.error, bus.busy);
        end
        tick();
        n_vec++;
        if (bus.error !== 1'b0) begin
            n_err++;
            $display("FAIL zero_bill_pulse got err=%b want 0", bus.error);
        end
    endtask

    task automatic test_start_while_busy();
        logic a1, r1;
        do_start(100);
        do_start(50);
        send_note(3'd2, a1, r1);
        tick();
        n_vec++;
        if (a1 !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL start_busy got ack=%b done=%b busy=%b want 1/0/1", a1, bus.done, bus.busy);
        end
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        tick();
    endtask

    task automatic test_max_notes();
        logic a, r;
        int n_ack;
        n_ack = 0;
        do_start(2047);
        for (int i = 0; i < MAX_NOTES; i++) begin
            send_note(3'd0, a, r);
            if (a === 1'b1) n_ack++;
        end
        send_note(3'd0, a, r);
        n_vec++;
        if (n_ack !== MAX_NOTES || a !== 1'b0 || r !== 1'b1) begin
            n_err++;
            $display("FAIL max_notes got acks=%0d last a/r=%b%b want %0d 01", n_ack, a, r, MAX_NOTES);
        end
        n_vec++;
        if (bus.tendered !== 12'd150) begin
            n_err++;
            $display("FAIL max_notes_tendered got %0d want 150", bus.tendered);
        end
        tick();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic a, r;
        int d0;
        do_start(1000);
        send_note(3'd4, a, r);
        send_note(3'd3, a, r);
        n_vec++;
        if (bus.tendered !== 12'd300) begin
            n_err++;
            $display("FAIL reset_mid_pre got %0d want 300", bus.tendered);
        end
        d0 = done_cnt;
        rst_n = 1'b0;
        tick();
        n_vec++;
        if ({bus.note_ack, bus.note_reject, bus.busy, bus.done, bus.paid_ok, bus.refund, bus.error} !== 7'b0
            || bus.tendered !== '0 || bus.change !== '0) begin
            n_err++;
            $display("FAIL reset_mid_outputs got flags=%b t=%0d c=%0d want all 0",
                     {bus.note_ack, bus.note_reject, bus.busy, bus.done, bus.paid_ok, bus.refund, bus.error},
                     bus.tendered, bus.change);
        end
        rst_n = 1'b1;
        tick(3);
        n_vec++;
        if (done_cnt !== d0) begin
            n_err++;
            $display("FAIL reset_mid_done got %0d done pulses want 0", done_cnt - d0);
        end
    endtask

    task automatic test_timeout();
        logic a, r;
        int n;
        do_start(50);
        send_note(3'd1, a, r);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (bus.done) break;
        end
`ifdef ATP_COLLECT_TIMEOUT_EN
        n_vec++;
        if (n !== TIMEOUT_CYC || {bus.done, bus.refund, bus.error, bus.paid_ok} !== 4'b1110
            || bus.change !== 12'd20) begin
            n_err++;
            $display("FAIL timeout got n=%0d d/r/e/p=%b change=%0d want n=%0d 1110 change=20",
                     n, {bus.done, bus.refund, bus.error, bus.paid_ok}, bus.change, TIMEOUT_CYC);
        end
        tick();
`else
        n_vec++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || n !== 40) begin
            n_err++;
            $display("FAIL no_timeout got done=%b busy=%b n=%0d want 0/1/40", bus.done, bus.busy, n);
        end
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        tick();
`endif
    endtask

    task automatic test_random();
        logic a, r;
        int bill, code, gap, last_prog, tries, nv;
        bit exp_acc, finished;
        for (int t = 0; t < 40; t++) begin
            bill = $urandom_range(1, 1500);
            m_tend = 0;
            m_notes = 0;
            do_start(bill);
            last_prog = cyc;
            n_vec++;
            if (bus.busy !== 1'b1 || bus.tendered !== '0) begin
                n_err++;
                $display("FAIL rnd_start got busy=%b t=%0d want 1/0", bus.busy, bus.tendered);
            end
            finished = 1'b0;
            tries = 0;
            while (!finished) begin
                tries++;
                if ($urandom_range(0, 11) == 0 || tries > 30 || (cyc - last_prog) > 10) begin
                    tick();
                    nv = int'($urandom_range(0, 1));
                    bus.cancel = 1'b1;
                    bus.note_valid = nv[0];
                    bus.note_code = 3'($urandom_range(0, 7));
                    tick();
                    bus.cancel = 1'b0;
                    bus.note_valid = 1'b0;
                    n_vec++;
                    if ({bus.done, bus.refund, bus.paid_ok, bus.note_ack, bus.note_reject} !== {4'b1100, nv[0]}
                        || bus.change !== TOT_W'(m_tend)) begin
                        n_err++;
                        $display("FAIL rnd_cancel got d/r/p/a/j=%b change=%0d want %b change=%0d",
                                 {bus.done, bus.refund, bus.paid_ok, bus.note_ack, bus.note_reject},
                                 bus.change, {4'b1100, nv[0]}, m_tend);
                    end
                    tick();
                    finished = 1'b1;
                end else begin
                    code = $urandom_range(0, 7);
                    exp_acc = model_accepts(code);
                    send_note(3'(code), a, r);
                    if (exp_acc) begin
                        m_tend += den_tab[code];
                        m_notes++;
                        last_prog = cyc;
                    end
                    n_vec++;
                    if (a !== exp_acc || r !== !exp_acc || bus.tendered !== TOT_W'(m_tend)) begin
                        n_err++;
                        $display("FAIL rnd_note code=%0d got a/r=%b%b t=%0d want a=%0d t=%0d",
                                 code, a, r, bus.tendered, exp_acc, m_tend);
                    end
                    if (m_tend >= bill) begin
                        tick();
                        n_vec++;
                        if ({bus.done, bus.paid_ok, bus.refund} !== 3'b110
                            || bus.change !== TOT_W'(m_tend - bill)) begin
                            n_err++;
                            $display("FAIL rnd_settle got d/p/r=%b change=%0d want 110 change=%0d",
                                     {bus.done, bus.paid_ok, bus.refund}, bus.change, m_tend - bill);
                        end
                        tick();
                        finished = 1'b1;
                    end else begin
                        gap = $urandom_range(0, 2);
                        if (gap > 0) tick(gap);
                    end
                end
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.bill_amount = '0;
        bus.cancel = 1'b0;
        bus.note_valid = 1'b0;
        bus.note_code = 3'd0;
        test_reset();
        test_paid_two_notes();
        test_held_note();
        test_reject_then_ack();
        test_cancel_with_note();
        test_zero_bill();
        test_start_while_busy();
        test_max_notes();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog got time limit reached want run complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end
endmodule
